// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the shared UART transmitter arbiter.
// Carries request levels, packed request bytes, and the per-grant responses.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              err;

    modport master (
        output req,
        output req_data,
        input  grant,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  req_data,
        output grant,
        output ack,
        output err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmitter among NREQ byte requesters (Baud16x domain).
// Round-robin by default; define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int BUSY_TIMEOUT  = 4,
    parameter int FRAME_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.slave      bus,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    input  logic                  tx_int,
    output logic                  active
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(FRAME_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              active_q, active_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  timer_inc;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
`endif

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [7:0]        req_byte [NREQ];

    // Completion keys off busy falling; Int_T is only advisory.
    logic unused_tx_int;
    assign unused_tx_int = tx_int;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
        assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(k);
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
`endif
    end

    assign timer_inc = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        err_d      = 1'b0;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        timer_d    = timer_inc;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (pick_found) begin
                    grant_d    = NREQ'(1) << pick_idx;
                    tx_data_d  = req_byte[pick_idx];
                    tx_start_d = 1'b1;
                    state_d    = S_START;
`ifndef UART_ARB_FIXED_PRIO_EN
                    win_d      = pick_idx;
`endif
                end
            end
            S_START: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                    timer_d = '0;
                end else if (timer_inc >= TMR_W'(BUSY_TIMEOUT)) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    tx_start_d = 1'b0;
                    timer_d    = '0;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d    = S_DONE;
                    ack_d      = grant_q;
                    tx_start_d = 1'b0;
                    timer_d    = '0;
                end else if (timer_inc >= TMR_W'(FRAME_TIMEOUT)) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    tx_start_d = 1'b0;
                    timer_d    = '0;
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
                timer_d = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
                rr_ptr_d = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
`endif
            end
            S_ERR: begin
                // Pointer left alone so the failed requester retries first.
                grant_d    = '0;
                tx_start_d = 1'b0;
                state_d    = S_IDLE;
                timer_d    = '0;
            end
            default: begin
                grant_d    = '0;
                tx_start_d = 1'b0;
                state_d    = S_IDLE;
                timer_d    = '0;
            end
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            active_q   <= 1'b0;
            timer_q    <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
            win_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            active_q   <= active_d;
            timer_q    <= timer_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign active    = active_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural 160-count 8N1 transmitter.
// Expected service order comes from an abstract queue model of the arbitration rule.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_int;
    logic       active;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(4), .FRAME_TIMEOUT(200)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_int   (tx_int),
        .active   (active)
    );

    // Transmitter model: launches on a start rising edge, busy for 161 cycles.
    logic       force_no_busy = 1'b0;
    logic       busy_r, tx_int_r, sp_m, tx_line;
    logic [9:0] shreg;
    logic [7:0] launched_byte;
    int         fcnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0; tx_int_r <= 1'b0; sp_m <= 1'b0; tx_line <= 1'b1;
            shreg <= '1; launched_byte <= 8'h00; fcnt <= 0;
        end else begin
            sp_m     <= tx_start;
            tx_int_r <= 1'b0;
            if (!busy_r) begin
                if (tx_start && !sp_m && !force_no_busy) begin
                    busy_r <= 1'b1; fcnt <= 0;
                    shreg <= {1'b1, tx_data, 1'b0};
                    launched_byte <= tx_data;
                end
            end else begin
                fcnt    <= fcnt + 1;
                tx_line <= (fcnt < 160) ? shreg[fcnt/16] : 1'b1;
                if (fcnt == 160) begin
                    busy_r <= 1'b0; tx_int_r <= 1'b1;
                end
            end
        end
    end
    assign tx_busy = busy_r;
    assign tx_int  = tx_int_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
    } exp_t;
    exp_t exp_q[$];
    int   rr_ptr_m = 0;
    int   checks = 0;
    int   failures = 0;
    int   grant_cyc = 0;
    int   ack_cyc = 0;
    int   err_seen = 0;
    bit   err_allowed = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: pending set served in cyclic order from the pointer (or index order when fixed).
    task automatic issue(input logic [NREQ-1:0] set);
        int last;
        int idx;
        exp_t e;
        last = -1;
        for (int k = 0; k < NREQ; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (rr_ptr_m + k) % NREQ;
`endif
            if (set[idx]) begin
                e.idx  = 4'(idx);
                e.data = bus.req_data[8*idx +: 8];
                exp_q.push_back(e);
                last = idx;
            end
        end
`ifndef UART_ARB_FIXED_PRIO_EN
        if (last >= 0) rr_ptr_m = (last + 1) % NREQ;
`endif
        bus.req = set;
    endtask

    task automatic drain(input int drop_idx);
        int  g;
        bit  done;
        g = 0;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
            g = (bus.grant != '0) ? g + 1 : 0;
            if (drop_idx >= 0 && g == 50 && bus.grant[drop_idx]) bus.req[drop_idx] = 1'b0;
            if (exp_q.size() == 0 && bus.req == '0 && !active) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0_pending", exp_q.size());
            exp_q.delete();
            bus.req = '0;
        end
    endtask

    // Monitor: compares grants, acks and errors against the scoreboard head.
    initial begin : monitor
        logic            sp;
        int              low;
        logic [NREQ-1:0] gp, oh;
        sp = 1'b0; low = 100; gp = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sp = 1'b0; low = 100; gp = '0;
                continue;
            end
            oh = (exp_q.size() > 0) ? NREQ'(1) << exp_q[0].idx : '0;
            if (bus.grant != '0 && gp == '0) begin
                grant_cyc = cyc;
                chk("grant", bus.grant, oh);
                if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q[0].data);
            end
            if (tx_start && !sp) chk("start_gap_ge2", low >= 2, 1);
            low = tx_start ? 0 : ((low < 100) ? low + 1 : low);
            if (bus.ack != '0) begin
                ack_cyc = cyc;
                chk("ack", bus.ack, oh);
                chk("ack_grant", bus.grant, oh);
                if (exp_q.size() > 0) begin
                    chk("ack_byte", launched_byte, exp_q[0].data);
                    $display("ack req=%0d data=%02h cycle=%0d", exp_q[0].idx, exp_q[0].data, cyc);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.err) begin
                err_seen++;
                chk("err_allowed", err_allowed, 1);
                chk("err_grant", bus.grant, oh);
            end
            gp = bus.grant;
            sp = tx_start;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int g, e, sel;
        bus.req = '0;
        bus.req_data = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_active", active, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("noreq_grant", bus.grant, 0);
        chk("noreq_active", active, 0);

        // Single request, ack latency from grant.
        bus.req_data[7:0] = 8'hA5;
        issue(4'b0001);
        $display("issue set=0001");
        drain(-1);
        chk("ack_latency", ack_cyc - grant_cyc, 163);

        // All four held, two rounds with distinct bytes.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = 8'(8'hA0 + 16*r + i);
            issue(4'b1111);
            $display("issue set=1111");
            drain(-1);
        end

        // Random request sets and bytes.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = 8'($urandom_range(0, 255));
            sel = $urandom_range(1, 15);
            issue(4'(sel));
            $display("issue set=%04b", 4'(sel));
            drain(-1);
        end

        // Transmitter never goes busy: timeout error, then retry succeeds.
        err_allowed = 1'b1;
        force_no_busy = 1'b1;
        err_seen = 0;
        bus.req_data[7:0] = 8'h3C;
        issue(4'b0001);
        $display("issue set=0001 busy_forced_low");
        g = -1; e = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (g < 0 && bus.grant != '0) g = c;
            if (bus.err) begin
                e = c;
                force_no_busy = 1'b0;
                break;
            end
        end
        force_no_busy = 1'b0;
        chk("err_latency", (e >= 0 && g >= 0) ? e - g : -1, 4);
        drain(-1);
        err_allowed = 1'b0;
        chk("err_count", err_seen, 1);

        // Reset mid-frame at cycle 80 of service.
        bus.req_data[15:8] = 8'h5A;
        issue(4'b0010);
        $display("issue set=0010 reset_mid_frame");
        g = 0;
        for (int c = 0; c < 300 && g < 80; c++) begin
            @(negedge clk);
            g = (bus.grant != '0) ? g + 1 : 0;
        end
        chk("reached_cycle80", g, 80);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_grant", bus.grant, 0);
        chk("abort_ack", bus.ack, 0);
        chk("abort_tx_start", tx_start, 0);
        chk("abort_tx_data", tx_data, 0);
        chk("abort_active", active, 0);
        chk("abort_line_idle", tx_line, 1);
        exp_q.delete();
        rr_ptr_m = 0;
        @(negedge clk);
        rst = 1'b1;
        issue(4'b0010);
        drain(-1);

        // Requester 2 drops its request 50 cycles into service.
        bus.req_data[23:16] = 8'hC3;
        issue(4'b0100);
        $display("issue set=0100 drop_mid_frame");
        drain(2);

        repeat (5) @(negedge clk);
        chk("final_active", active, 0);
        chk("final_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
